time_keeper: RTL and testbench

Time-of-day counter that sits directly downstream of the time-entry stage. While set mode is active it loads the six entered digit fields (hours, minutes, seconds as tens/ones) and validates them. Once set mode ends, it counts seconds from the loaded time, driven by an internal clock-cycle prescaler. It drives six 4-bit BCD digits to the display multiplexer, with wrap from 23:59:59 to 00:00:00.

---
 rtl/time_keeper.sv | 191 +++++++++++++++++++
 tb/tb_time_keeper.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/time_keeper.sv
// Time-of-day BCD counter: loads and validates entered digits while set_en is high, then counts seconds.
// All outputs registered, one-cycle load latency; no backpressure, the display side always accepts.
module time_keeper #(
  parameter int TICK_DIV = 100000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       set_en,
  input  logic       run_en,
  input  logic [5:0] in_hrs_tens,
  input  logic [5:0] in_hrs_ones,
  input  logic [5:0] in_min_tens,
  input  logic [5:0] in_min_ones,
  input  logic [5:0] in_sec_tens,
  input  logic [5:0] in_sec_ones,
  output logic [3:0] hrs_tens,
  output logic [3:0] hrs_ones,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       tick,
  output logic       day_wrap,
  output logic       load_err
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    MODE_HOLD = 2'd0,
    MODE_RUN  = 2'd1,
    MODE_SET  = 2'd2
  } mode_e;

  mode_e mode;

  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    hrs_tens_q, hrs_tens_d;
  logic [3:0]    hrs_ones_q, hrs_ones_d;
  logic [3:0]    min_tens_q, min_tens_d;
  logic [3:0]    min_ones_q, min_ones_d;
  logic [3:0]    sec_tens_q, sec_tens_d;
  logic [3:0]    sec_ones_q, sec_ones_d;
  logic          tick_q, tick_d;
  logic          day_wrap_q, day_wrap_d;
  logic          load_err_q, load_err_d;

  logic [3:0] inc_hrs_tens, inc_hrs_ones, inc_min_tens, inc_min_ones, inc_sec_tens, inc_sec_ones;
  logic       sec_ones_max, sec_tens_max, min_ones_max, min_tens_max, hrs_max;
  logic       carry_st, carry_mo, carry_mt, carry_hr;
  logic       in_valid;

  // Six-bit fields: any set upper bit pushes the value past every bound below.
  assign in_valid = (in_sec_ones <= 6'd9) && (in_min_ones <= 6'd9) && (in_hrs_ones <= 6'd9) &&
                    (in_sec_tens <= 6'd5) && (in_min_tens <= 6'd5) && (in_hrs_tens <= 6'd2) &&
                    ((in_hrs_tens != 6'd2) || (in_hrs_ones <= 6'd3));

  always_comb begin
    mode = MODE_HOLD;
    if (set_en) begin
      mode = MODE_SET;
    end else if (run_en) begin
      mode = MODE_RUN;
    end
  end

  assign sec_ones_max = (sec_ones_q == 4'd9);
  assign sec_tens_max = (sec_tens_q == 4'd5);
  assign min_ones_max = (min_ones_q == 4'd9);
  assign min_tens_max = (min_tens_q == 4'd5);
  assign hrs_max      = (hrs_tens_q == 4'd2) && (hrs_ones_q == 4'd3);

  assign carry_st = sec_ones_max;
  assign carry_mo = carry_st & sec_tens_max;
  assign carry_mt = carry_mo & min_ones_max;
  assign carry_hr = carry_mt & min_tens_max;

  always_comb begin
    inc_sec_ones = sec_ones_max ? 4'd0 : sec_ones_q + 4'd1;
    inc_sec_tens = sec_tens_q;
    inc_min_ones = min_ones_q;
    inc_min_tens = min_tens_q;
    inc_hrs_ones = hrs_ones_q;
    inc_hrs_tens = hrs_tens_q;
    if (carry_st) begin
      inc_sec_tens = sec_tens_max ? 4'd0 : sec_tens_q + 4'd1;
    end
    if (carry_mo) begin
      inc_min_ones = min_ones_max ? 4'd0 : min_ones_q + 4'd1;
    end
    if (carry_mt) begin
      inc_min_tens = min_tens_max ? 4'd0 : min_tens_q + 4'd1;
    end
    if (carry_hr) begin
      if (hrs_max) begin
        inc_hrs_tens = 4'd0;
        inc_hrs_ones = 4'd0;
      end else if (hrs_ones_q == 4'd9) begin
        inc_hrs_tens = hrs_tens_q + 4'd1;
        inc_hrs_ones = 4'd0;
      end else begin
        inc_hrs_ones = hrs_ones_q + 4'd1;
      end
    end
  end

  always_comb begin
    presc_d    = presc_q;
    hrs_tens_d = hrs_tens_q;
    hrs_ones_d = hrs_ones_q;
    min_tens_d = min_tens_q;
    min_ones_d = min_ones_q;
    sec_tens_d = sec_tens_q;
    sec_ones_d = sec_ones_q;
    tick_d     = 1'b0;
    day_wrap_d = 1'b0;
    load_err_d = load_err_q;
    case (mode)
      MODE_SET: begin
        presc_d = '0;
        if (in_valid) begin
          hrs_tens_d = in_hrs_tens[3:0];
          hrs_ones_d = in_hrs_ones[3:0];
          min_tens_d = in_min_tens[3:0];
          min_ones_d = in_min_ones[3:0];
          sec_tens_d = in_sec_tens[3:0];
          sec_ones_d = in_sec_ones[3:0];
          load_err_d = 1'b0;
        end else begin
          load_err_d = 1'b1;
        end
      end
      MODE_RUN: begin
        if (presc_q == PRESC_MAX) begin
          presc_d    = '0;
          tick_d     = 1'b1;
          day_wrap_d = carry_hr & hrs_max;
          hrs_tens_d = inc_hrs_tens;
          hrs_ones_d = inc_hrs_ones;
          min_tens_d = inc_min_tens;
          min_ones_d = inc_min_ones;
          sec_tens_d = inc_sec_tens;
          sec_ones_d = inc_sec_ones;
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      default: begin
        presc_d = presc_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q    <= '0;
      hrs_tens_q <= 4'd0;
      hrs_ones_q <= 4'd0;
      min_tens_q <= 4'd0;
      min_ones_q <= 4'd0;
      sec_tens_q <= 4'd0;
      sec_ones_q <= 4'd0;
      tick_q     <= 1'b0;
      day_wrap_q <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      hrs_tens_q <= hrs_tens_d;
      hrs_ones_q <= hrs_ones_d;
      min_tens_q <= min_tens_d;
      min_ones_q <= min_ones_d;
      sec_tens_q <= sec_tens_d;
      sec_ones_q <= sec_ones_d;
      tick_q     <= tick_d;
      day_wrap_q <= day_wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign hrs_tens = hrs_tens_q;
  assign hrs_ones = hrs_ones_q;
  assign min_tens = min_tens_q;
  assign min_ones = min_ones_q;
  assign sec_tens = sec_tens_q;
  assign sec_ones = sec_ones_q;
  assign tick     = tick_q;
  assign day_wrap = day_wrap_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_time_keeper.sv
// Directed bench for time_keeper with a 4-cycle second.
module tb_time_keeper;

  logic       clk;
  logic       rst_n;
  logic       set_en;
  logic       run_en;
  logic [5:0] in_hrs_tens, in_hrs_ones, in_min_tens, in_min_ones, in_sec_tens, in_sec_ones;
  logic [3:0] hrs_tens, hrs_ones, min_tens, min_ones, sec_tens, sec_ones;
  logic       tick;
  logic       day_wrap;
  logic       load_err;
  logic [23:0] tod;

  int n_checks;
  int n_errs;

  time_keeper #(.TICK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .set_en(set_en), .run_en(run_en),
    .in_hrs_tens(in_hrs_tens), .in_hrs_ones(in_hrs_ones),
    .in_min_tens(in_min_tens), .in_min_ones(in_min_ones),
    .in_sec_tens(in_sec_tens), .in_sec_ones(in_sec_ones),
    .hrs_tens(hrs_tens), .hrs_ones(hrs_ones),
    .min_tens(min_tens), .min_ones(min_ones),
    .sec_tens(sec_tens), .sec_ones(sec_ones),
    .tick(tick), .day_wrap(day_wrap), .load_err(load_err)
  );

  assign tod = {hrs_tens, hrs_ones, min_tens, min_ones, sec_tens, sec_ones};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load(input logic [5:0] ht, input logic [5:0] ho, input logic [5:0] mt,
                      input logic [5:0] mo, input logic [5:0] st, input logic [5:0] so);
    set_en      = 1'b1;
    in_hrs_tens = ht;
    in_hrs_ones = ho;
    in_min_tens = mt;
    in_min_ones = mo;
    in_sec_tens = st;
    in_sec_ones = so;
    step(1);
    set_en = 1'b0;
  endtask

  logic [23:0] wrap_seq [5];
  logic        saw_tick;

  initial begin
    n_checks = 0;
    n_errs   = 0;
    wrap_seq[0] = 24'h235956;
    wrap_seq[1] = 24'h235957;
    wrap_seq[2] = 24'h235958;
    wrap_seq[3] = 24'h235959;
    wrap_seq[4] = 24'h000000;

    rst_n = 1'b0;
    set_en = 1'b0;
    run_en = 1'b0;
    in_hrs_tens = '0; in_hrs_ones = '0; in_min_tens = '0;
    in_min_ones = '0; in_sec_tens = '0; in_sec_ones = '0;
    #2;
    chk("reset_tod", 32'(tod), 32'h000000);
    chk("reset_err", 32'(load_err), 32'd0);
    chk("reset_tick", 32'({tick, day_wrap}), 32'd0);
    #10 rst_n = 1'b1;
    step(1);

    // Load 23:59:55, then run through midnight.
    load(6'd2, 6'd3, 6'd5, 6'd9, 6'd5, 6'd5);
    chk("load_235955", 32'(tod), 32'h235955);
    chk("load_err_clear", 32'(load_err), 32'd0);
    run_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step(3);
      chk("pre_tick_low", 32'(tick), 32'd0);
      step(1);
      chk("tick_pulse", 32'(tick), 32'd1);
      chk("tick_tod", 32'(tod), 32'(wrap_seq[k]));
      chk("day_wrap", 32'(day_wrap), (k == 4) ? 32'd1 : 32'd0);
    end
    step(1);
    chk("tick_one_cycle", 32'(tick), 32'd0);
    chk("wrap_one_cycle", 32'(day_wrap), 32'd0);

    // Invalid entry keeps digits and sets a sticky error.
    run_en = 1'b0;
    load(6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6);
    chk("load_123456", 32'(tod), 32'h123456);
    load(6'd2, 6'd4, 6'd3, 6'd4, 6'd5, 6'd6);
    chk("bad_hrs_tod", 32'(tod), 32'h123456);
    chk("bad_hrs_err", 32'(load_err), 32'd1);
    step(3);
    chk("err_sticky", 32'(load_err), 32'd1);
    load(6'd0, 6'd1, 6'd0, 6'd2, 6'd0, 6'd3);
    chk("load_010203", 32'(tod), 32'h010203);
    chk("good_err_clear", 32'(load_err), 32'd0);
    load(6'd0, 6'd1, 6'd16, 6'd2, 6'd0, 6'd3);
    chk("bad_upper_bits", 32'(load_err), 32'd1);
    load(6'd1, 6'd9, 6'd5, 6'd9, 6'd6, 6'd0);
    chk("bad_sec_tens", 32'({load_err, tod}), 32'h1010203);

    // Carry chain cases.
    run_en = 1'b1;
    load(6'd0, 6'd9, 6'd5, 6'd9, 6'd5, 6'd9);
    step(4);
    chk("carry_09_10", 32'({tick, tod}), 32'h1100000);
    load(6'd1, 6'd9, 6'd5, 6'd9, 6'd5, 6'd9);
    step(4);
    chk("carry_19_20", 32'({tick, tod}), 32'h1200000);
    load(6'd0, 6'd0, 6'd0, 6'd9, 6'd5, 6'd9);
    step(4);
    chk("carry_min", 32'({tick, tod}), 32'h1001000);

    // SET wins over a pending prescaler wrap.
    load(6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0);
    step(3);
    load(6'd1, 6'd1, 6'd1, 6'd1, 6'd1, 6'd1);
    chk("set_wins_tick", 32'(tick), 32'd0);
    chk("set_wins_tod", 32'(tod), 32'h111111);

    // Hold preserves the partial second.
    step(4);
    chk("hold_pre_tick", 32'({tick, tod}), 32'h1111112);
    step(2);
    run_en = 1'b0;
    saw_tick = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      saw_tick = saw_tick | tick;
    end
    chk("hold_no_tick", 32'({saw_tick, tod}), 32'h0111112);
    run_en = 1'b1;
    step(1);
    chk("resume_first", 32'(tick), 32'd0);
    step(1);
    chk("resume_tick", 32'({tick, tod}), 32'h1111113);

    // Asynchronous reset between edges.
    load(6'd0, 6'd5, 6'd0, 6'd6, 6'd0, 6'd7);
    step(2);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_tod", 32'({load_err, tick, tod}), 32'h0);
    #2 rst_n = 1'b1;
    step(3);
    chk("post_rst_no_tick", 32'(tick), 32'd0);
    step(1);
    chk("post_rst_tick", 32'({tick, tod}), 32'h1000001);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
